// File: rtl/mmc3_irq_unit.sv
// MMC3-family scanline IRQ engine: M2-filtered PPU A12 edge detection,
// reloadable down-counter with MMC3A/MMC3B zero rule, and save-state readout.
module mmc3_irq_unit #(
  parameter int unsigned A12_FILTER = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_m2,
  input  logic             i_ppu_a12,
  input  logic             i_mmc3a,
  input  logic             i_wr_latch,
  input  logic             i_wr_reload,
  input  logic             i_wr_irq_off,
  input  logic             i_wr_irq_on,
  input  logic [CNT_W-1:0] i_din,
  output logic             o_irq_n,
  input  logic [1:0]       i_ss_addr,
  output logic [7:0]       o_ss_dout_c
);

  localparam int unsigned LOW_W = 3;

  logic             r_m2_d;
  logic             r_a12_d;
  logic [LOW_W-1:0] r_low_cnt;
  logic [CNT_W-1:0] r_latch;
  logic [CNT_W-1:0] r_counter;
  logic             r_reload;
  logic             r_irq_en;
  logic             r_irq_pend;

  logic             w_m2_fall;
  logic             w_a12_rise;
  logic             w_clk_evt;
  logic [CNT_W-1:0] w_cnt_evt;
  logic             w_evt_fire;
  logic [LOW_W-1:0] w_low_next;
  logic [CNT_W-1:0] w_latch_next;
  logic [CNT_W-1:0] w_counter_next;
  logic             w_reload_next;
  logic             w_irq_en_next;
  logic             w_irq_pend_next;

  assign w_m2_fall  = r_m2_d & ~i_m2;
  assign w_a12_rise = ~r_a12_d & i_ppu_a12;
  assign w_clk_evt  = w_a12_rise & (r_low_cnt == LOW_W'(A12_FILTER));

  // Value the counter takes on an event; never decrements from zero.
  assign w_cnt_evt  = ((r_counter == '0) || r_reload) ? r_latch
                                                      : r_counter - CNT_W'(1);
  // MMC3A suppresses the IRQ when an idle zero counter reloads to zero.
  assign w_evt_fire = (w_cnt_evt == '0) &&
                      (!i_mmc3a || (r_counter != '0) || r_reload);

  always_comb begin
    w_low_next      = r_low_cnt;
    w_latch_next    = r_latch;
    w_counter_next  = r_counter;
    w_reload_next   = r_reload;
    w_irq_en_next   = r_irq_en;
    w_irq_pend_next = r_irq_pend;

    if (i_ppu_a12) begin
      w_low_next = '0;
    end else if (w_m2_fall && (r_low_cnt != LOW_W'(A12_FILTER))) begin
      w_low_next = r_low_cnt + LOW_W'(1);
    end

    if (w_clk_evt) begin
      w_counter_next = w_cnt_evt;
      w_reload_next  = 1'b0;
      if (r_irq_en && w_evt_fire) begin
        w_irq_pend_next = 1'b1;
      end
    end

    // CPU writes override a coincident event.
    if (i_wr_reload) begin
      w_counter_next = '0;
      w_reload_next  = 1'b1;
    end else if (i_wr_latch) begin
      w_latch_next = i_din;
    end

    if (i_wr_irq_off) begin
      w_irq_en_next   = 1'b0;
      w_irq_pend_next = 1'b0;
    end else if (i_wr_irq_on) begin
      w_irq_en_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_m2_d     <= 1'b0;
      r_a12_d    <= 1'b0;
      r_low_cnt  <= '0;
      r_latch    <= '0;
      r_counter  <= '0;
      r_reload   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq_pend <= 1'b0;
      o_irq_n    <= 1'b1;
    end else begin
      r_m2_d     <= i_m2;
      r_a12_d    <= i_ppu_a12;
      r_low_cnt  <= w_low_next;
      r_latch    <= w_latch_next;
      r_counter  <= w_counter_next;
      r_reload   <= w_reload_next;
      r_irq_en   <= w_irq_en_next;
      r_irq_pend <= w_irq_pend_next;
      o_irq_n    <= ~w_irq_pend_next;
    end
  end

  always_comb begin
    o_ss_dout_c = '0;
    case (i_ss_addr)
      2'd0:    o_ss_dout_c = 8'(r_latch);
      2'd1:    o_ss_dout_c = 8'(r_counter);
      2'd2:    o_ss_dout_c = {5'b0, r_reload, r_irq_en, r_irq_pend};
      default: o_ss_dout_c = {5'b0, r_low_cnt};
    endcase
  end

endmodule
